// File: rtl/maxpool_stream.sv
// Streaming max-pool stage: reduces each window of win_w*win_h signed samples
// to its maximum (optionally ReLU-clamped) and emits one result per window.
module maxpool_stream #(
   parameter int unsigned DATA_SIZE   = 8,
   parameter int unsigned MAX_WINDOWS = 256
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_set_param,
   input  logic [7:0]           i_win_width,
   input  logic [7:0]           i_win_height,
   input  logic [15:0]          i_win_count,
   input  logic                 i_relu_en,
   output logic                 o_set_param_done,
   input  logic                 i_start,
   input  logic                 i_terminate,
   input  logic [DATA_SIZE-1:0] i_data,
   input  logic                 i_valid,
   input  logic                 i_read_done,
   output logic [DATA_SIZE-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error
);

   localparam int unsigned CW = $clog2(MAX_WINDOWS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [15:0]          win_size_q, win_size_d;
   logic [15:0]          win_count_q, win_count_d;
   logic                 relu_q, relu_d;
   logic [15:0]          elem_cnt_q, elem_cnt_d;
   logic [CW-1:0]        win_cnt_q, win_cnt_d;
   logic [DATA_SIZE-1:0] acc_q, acc_d;
   logic [DATA_SIZE-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 spd_q, spd_d;

   logic [15:0]          prod_c;
   logic [DATA_SIZE-1:0] cand_c;
   logic                 last_elem_c;
   logic                 last_win_c;

   assign prod_c      = 16'(i_win_width) * 16'(i_win_height);
   // First sample of a window replaces the accumulator outright.
   assign cand_c      = ((elem_cnt_q == 16'd0) || ($signed(i_data) > $signed(acc_q))) ? i_data : acc_q;
   assign last_elem_c = (elem_cnt_q == win_size_q - 16'd1);
   assign last_win_c  = (16'(win_cnt_q) == win_count_q - 16'd1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         win_size_q  <= '0;
         win_count_q <= '0;
         relu_q      <= 1'b0;
         elem_cnt_q  <= '0;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         spd_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_size_q  <= win_size_d;
         win_count_q <= win_count_d;
         relu_q      <= relu_d;
         elem_cnt_q  <= elem_cnt_d;
         win_cnt_q   <= win_cnt_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         spd_q       <= spd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      win_size_d  = win_size_q;
      win_count_d = win_count_q;
      relu_d      = relu_q;
      elem_cnt_d  = elem_cnt_q;
      win_cnt_d   = win_cnt_q;
      acc_d       = acc_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      error_d     = error_q;
      spd_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_set_param) begin
               win_size_d  = (prod_c == 16'd0) ? 16'd1 : prod_c;
               win_count_d = (i_win_count == 16'd0) ? 16'd1 : i_win_count;
               relu_d      = i_relu_en;
               spd_d       = 1'b1;
            end
            if (i_start) begin
               state_d    = S_RUN;
               elem_cnt_d = '0;
               win_cnt_d  = '0;
               error_d    = 1'b0;
            end
         end
         S_RUN: begin
            if (i_valid) begin
               acc_d = cand_c;
               if (last_elem_c) begin
                  elem_cnt_d = '0;
                  win_cnt_d  = win_cnt_q + CW'(1);
                  valid_d    = 1'b1;
                  data_d     = (relu_q && cand_c[DATA_SIZE-1]) ? '0 : cand_c;
                  if (last_win_c) state_d = S_DONE;
               end else begin
                  elem_cnt_d = elem_cnt_q + 16'd1;
               end
            end
            // Upstream ended early unless this very sample finishes the run.
            if (i_read_done && !(i_valid && last_elem_c && last_win_c)) begin
               state_d    = S_IDLE;
               elem_cnt_d = '0;
               error_d    = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (i_terminate) begin
         state_d    = S_IDLE;
         elem_cnt_d = '0;
         win_cnt_d  = '0;
         valid_d    = 1'b0;
         done_d     = 1'b0;
      end
   end

   assign busy_d = (state_d == S_RUN);

   assign o_data           = data_q;
   assign o_valid          = valid_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_error          = error_q;
   assign o_set_param_done = spd_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: hand-computed window maxima, ReLU,
// gaps, early read_done, terminate and reset behaviour.
module tb_maxpool_stream;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_set_param = 1'b0;
   logic [7:0]  i_win_width = '0;
   logic [7:0]  i_win_height = '0;
   logic [15:0] i_win_count = '0;
   logic        i_relu_en = 1'b0;
   logic        o_set_param_done;
   logic        i_start = 1'b0;
   logic        i_terminate = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_valid = 1'b0;
   logic        i_read_done = 1'b0;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_busy;
   logic        o_done;
   logic        o_error;

   int tests = 0;
   int fails = 0;

   maxpool_stream #(.DATA_SIZE(8), .MAX_WINDOWS(256)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_set_param(i_set_param),
      .i_win_width(i_win_width), .i_win_height(i_win_height),
      .i_win_count(i_win_count), .i_relu_en(i_relu_en),
      .o_set_param_done(o_set_param_done), .i_start(i_start),
      .i_terminate(i_terminate), .i_data(i_data), .i_valid(i_valid),
      .i_read_done(i_read_done), .o_data(o_data), .o_valid(o_valid),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   // Drive one clock of stream inputs; outputs are examined 1 ns after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic rd);
      i_valid = v; i_data = d; i_read_done = rd;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_read_done = 1'b0;
   endtask

   task automatic configure(input logic [7:0] w, input logic [7:0] h,
                            input logic [15:0] c, input logic relu);
      i_win_width = w; i_win_height = h; i_win_count = c; i_relu_en = relu;
      i_set_param = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);
      i_set_param = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic start_run();
      i_start = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if ({o_data, o_valid, o_busy, o_done, o_error, o_set_param_done} !== 13'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h want 0",
                  {o_data, o_valid, o_busy, o_done, o_error, o_set_param_done});
      end
      i_reset = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_set_param();
      i_win_width = 8'd2; i_win_height = 8'd2; i_win_count = 16'd2; i_relu_en = 1'b0;
      i_set_param = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);
      i_set_param = 1'b0;
      tests++;
      if (o_set_param_done !== 1'b1) begin
         fails++; $display("FAIL set_param_done: got %b want 1", o_set_param_done);
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_set_param_done !== 1'b0) begin
         fails++; $display("FAIL set_param_done_pulse: got %b want 0", o_set_param_done);
      end
   endtask

   // 2x2, two windows, relu off; a mid-run set_param must be ignored.
   task automatic test_basic();
      logic [7:0] s [8];
      s = '{8'sd3, -8'sd7, 8'sd9, 8'sd1, 8'sd0, -8'sd2, -8'sd5, 8'sd4};
      start_run();
      tests++;
      if (o_busy !== 1'b1) begin fails++; $display("FAIL t1_busy: got %b want 1", o_busy); end
      for (int i = 0; i < 8; i++) begin
         i_win_width = 8'd1; i_win_height = 8'd1;
         i_set_param = (i == 1);
         cycle(1'b1, s[i], 1'b0);
         i_set_param = 1'b0;
         tests++;
         if (o_valid !== ((i == 3) || (i == 7))) begin
            fails++; $display("FAIL t1_valid[%0d]: got %b want %b", i, o_valid, (i == 3) || (i == 7));
         end
         if (i == 2) begin
            tests++;
            if (o_set_param_done !== 1'b0) begin
               fails++; $display("FAIL t1_param_ignored: got %b want 0", o_set_param_done);
            end
         end
         if (i == 3 || i == 7) begin
            tests++;
            if (o_data !== ((i == 3) ? 8'd9 : 8'd4) || o_done !== 1'b0) begin
               fails++; $display("FAIL t1_data[%0d]: got %0d done %b want %0d done 0",
                                 i, $signed(o_data), o_done, (i == 3) ? 9 : 4);
            end
         end
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_done !== 1'b1 || o_valid !== 1'b0) begin
         fails++; $display("FAIL t1_done: got done %b valid %b want 1 0", o_done, o_valid);
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL t1_idle: got done %b busy %b want 0 0", o_done, o_busy);
      end
   endtask

   // ReLU on/off for a negative window, and the all -128 window.
   task automatic test_relu();
      logic [7:0] s [4];
      logic [7:0] exp_v;
      for (int k = 0; k < 4; k++) begin
         if (k < 2) s = '{-8'sd8, -8'sd3, -8'sd100, -8'sd1};
         else       s = '{8'h80, 8'h80, 8'h80, 8'h80};
         exp_v = (k[0] == 1'b0) ? 8'h00 : ((k < 2) ? 8'hFF : 8'h80);
         configure(8'd2, 8'd2, 16'd1, (k[0] == 1'b0));
         start_run();
         for (int i = 0; i < 4; i++) cycle(1'b1, s[i], 1'b0);
         tests++;
         if (o_valid !== 1'b1 || o_data !== exp_v) begin
            fails++; $display("FAIL t2_relu[%0d]: got valid %b data %0d want 1 %0d",
                              k, o_valid, $signed(o_data), $signed(exp_v));
         end
         cycle(1'b0, 8'h00, 1'b0);
         cycle(1'b0, 8'h00, 1'b0);
      end
   endtask

   // 1x1 windows: each sample is its own result one cycle later.
   task automatic test_back_to_back();
      logic [7:0] s [3];
      s = '{8'sd5, -8'sd6, 8'sd7};
      configure(8'd1, 8'd1, 16'd3, 1'b0);
      start_run();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, s[i], 1'b0);
         tests++;
         if (o_valid !== 1'b1 || o_data !== s[i] || o_done !== 1'b0) begin
            fails++; $display("FAIL t3_out[%0d]: got valid %b data %0d done %b want 1 %0d 0",
                              i, o_valid, $signed(o_data), o_done, $signed(s[i]));
         end
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_done !== 1'b1 || o_valid !== 1'b0) begin
         fails++; $display("FAIL t3_done: got done %b valid %b want 1 0", o_done, o_valid);
      end
      cycle(1'b0, 8'h00, 1'b0);
   endtask

   // 3x3 with i_valid toggling; gap cycles carry junk data that must be ignored.
   task automatic test_gaps();
      logic [7:0] s [18];
      logic [7:0] res [2];
      int nv, nd;
      s = '{8'sd1, 8'sd2, 8'sd3, -8'sd4, 8'sd50, 8'sd6, 8'sd7, 8'sd8, 8'sd9,
            -8'sd1, -8'sd2, -8'sd3, -8'sd4, -8'sd5, -8'sd6, -8'sd7, -8'sd8, -8'sd9};
      res = '{8'h00, 8'h00};
      nv = 0; nd = 0;
      configure(8'd3, 8'd3, 16'd2, 1'b0);
      start_run();
      for (int i = 0; i < 22; i++) begin
         if (i < 18) begin
            cycle(1'b0, 8'sd120, 1'b0);
            if (o_valid) begin if (nv < 2) res[nv] = o_data; nv++; end
            if (o_done) nd++;
            cycle(1'b1, s[i], 1'b0);
         end else begin
            cycle(1'b1, 8'sd120, 1'b0);
         end
         if (o_valid) begin if (nv < 2) res[nv] = o_data; nv++; end
         if (o_done) nd++;
      end
      tests++;
      if (nv != 2 || nd != 1) begin
         fails++; $display("FAIL t4_counts: got valid %0d done %0d want 2 1", nv, nd);
      end
      tests++;
      if (res[0] !== 8'd50 || res[1] !== 8'hFF) begin
         fails++; $display("FAIL t4_data: got %0d %0d want 50 -1", $signed(res[0]), $signed(res[1]));
      end
   endtask

   // Early read_done raises sticky error; read_done with the final sample does not.
   task automatic test_read_done();
      int nv, nd;
      logic [7:0] last;
      nv = 0; nd = 0; last = '0;
      configure(8'd2, 8'd2, 16'd3, 1'b0);
      start_run();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         if (o_valid) begin nv++; last = o_data; end
      end
      cycle(1'b0, 8'h00, 1'b1);
      tests++;
      if (o_error !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
         fails++; $display("FAIL t5_error: got err %b busy %b valid %b want 1 0 0", o_error, o_busy, o_valid);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'sd1, 1'b0);
         if (o_done) nd++;
         if (o_valid) nv++;
      end
      tests++;
      if (nv != 2 || nd != 0 || last !== 8'd8) begin
         fails++; $display("FAIL t5_outputs: got valid %0d done %0d last %0d want 2 0 8", nv, nd, last);
      end
      start_run();
      tests++;
      if (o_error !== 1'b0) begin fails++; $display("FAIL t5_clear: got %b want 0", o_error); end
      i_terminate = 1'b1; cycle(1'b0, 8'h00, 1'b0); i_terminate = 1'b0;

      configure(8'd2, 8'd2, 16'd1, 1'b0);
      start_run();
      cycle(1'b1, 8'sd4, 1'b0);
      cycle(1'b1, 8'sd2, 1'b0);
      cycle(1'b1, 8'sd6, 1'b0);
      cycle(1'b1, 8'sd3, 1'b1);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 8'd6 || o_error !== 1'b0) begin
         fails++; $display("FAIL t5_final_rd: got valid %b data %0d err %b want 1 6 0",
                           o_valid, $signed(o_data), o_error);
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_done !== 1'b1 || o_error !== 1'b0) begin
         fails++; $display("FAIL t5_final_done: got done %b err %b want 1 0", o_done, o_error);
      end
      cycle(1'b0, 8'h00, 1'b0);
   endtask

   // Terminate and reset mid-run; fresh runs must start from element 0.
   task automatic test_abort();
      int nv, nd;
      nv = 0; nd = 0;
      configure(8'd2, 8'd2, 16'd2, 1'b0);
      start_run();
      cycle(1'b1, 8'sd10, 1'b0);
      cycle(1'b1, 8'sd20, 1'b0);
      i_terminate = 1'b1;
      cycle(1'b1, 8'sd100, 1'b0);
      i_terminate = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'sd30, 1'b0);
         if (o_valid) nv++;
         if (o_done) nd++;
      end
      tests++;
      if (nv != 0 || nd != 0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL t6_term: got valid %0d done %0d busy %b want 0 0 0", nv, nd, o_busy);
      end
      start_run();
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         tests++;
         if (o_valid !== (i == 4) || (i == 4 && o_data !== 8'd4)) begin
            fails++; $display("FAIL t6_fresh[%0d]: got valid %b data %0d want %b 4",
                              i, o_valid, $signed(o_data), i == 4);
         end
      end
      i_terminate = 1'b1; cycle(1'b0, 8'h00, 1'b0); i_terminate = 1'b0;

      start_run();
      cycle(1'b1, 8'sd7, 1'b0);
      cycle(1'b1, 8'sd8, 1'b0);
      i_reset = 1'b1;
      cycle(1'b1, 8'sd9, 1'b0);
      i_reset = 1'b0;
      tests++;
      if ({o_valid, o_busy, o_done, o_error} !== 4'd0) begin
         fails++; $display("FAIL t6_reset: got %b want 0000", {o_valid, o_busy, o_done, o_error});
      end
      nv = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'sd9, 1'b0);
         if (o_valid || o_done) nv++;
      end
      tests++;
      if (nv != 0) begin fails++; $display("FAIL t6_reset_quiet: got %0d want 0", nv); end
      configure(8'd2, 8'd2, 16'd1, 1'b0);
      start_run();
      cycle(1'b1, -8'sd1, 1'b0);
      cycle(1'b1, -8'sd2, 1'b0);
      cycle(1'b1, -8'sd3, 1'b0);
      cycle(1'b1, -8'sd4, 1'b0);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 8'hFF) begin
         fails++; $display("FAIL t6_after_reset: got valid %b data %0d want 1 -1", o_valid, $signed(o_data));
      end
      cycle(1'b0, 8'h00, 1'b0);
      tests++;
      if (o_done !== 1'b1) begin fails++; $display("FAIL t6_after_done: got %b want 1", o_done); end
      cycle(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_set_param();
      test_basic();
      test_relu();
      test_back_to_back();
      test_gaps();
      test_read_done();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
